// File: rtl/imem_port.sv
// Instruction-memory responder: serves fetch-stage PCs from an external async SRAM and
// arbitrates one MEM-stage load/store port onto the same SRAM, with one-fetch fairness.
module imem_port #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [15:0] NOP_INSTR   = 16'h0800
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] pc_i,
  output logic        stall_pc_o,
  output logic [15:0] instr_o,
  output logic [15:0] instr_pc_o,
  output logic        instr_valid_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [15:0] mem_addr_i,
  input  logic [15:0] mem_wdata_i,
  output logic [15:0] mem_rdata_o,
  output logic        mem_ack_o,
  output logic [15:0] ram_addr_o,
  output logic [15:0] ram_data_o,
  input  logic [15:0] ram_data_i,
  output logic        ram_data_oe_o,
  output logic        ram_en_n_o,
  output logic        ram_oe_n_o,
  output logic        ram_we_n_o
);

  typedef enum logic [2:0] {
    S_F,
    S_D_RD,
    S_D_SETUP,
    S_D_WE,
    S_D_HOLD
  } state_e;

  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        fair_q, fair_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic [15:0] rdata_q, rdata_d;
  logic        ack;
  logic        rd_last;

  // NOTE: every signal written here gets its default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    fair_d        = fair_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = 1'b0;
    rdata_d       = rdata_q;
    stall_pc_o    = 1'b1;
    ack           = 1'b0;
    rd_last       = 1'b0;

    unique case (state_q)
      S_F: begin
        if (cnt_q == 4'd0 && mem_req_i && !fair_q) begin
          addr_d  = mem_addr_i;
          wdata_d = mem_wdata_i;
          state_d = mem_we_i ? S_D_SETUP : S_D_RD;
        end else if (cnt_q == CNT_LAST) begin
          stall_pc_o    = 1'b0;
          instr_d       = ram_data_i;
          instr_pc_d    = pc_i;
          instr_valid_d = 1'b1;
          cnt_d         = 4'd0;
          fair_d        = 1'b0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_D_RD: begin
        if (cnt_q == CNT_LAST) begin
          rd_last = 1'b1;
          ack     = 1'b1;
          rdata_d = ram_data_i;
          state_d = S_F;
          cnt_d   = 4'd0;
          fair_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_D_SETUP: state_d = S_D_WE;
      S_D_WE:    state_d = S_D_HOLD;
      S_D_HOLD: begin
        ack     = 1'b1;
        state_d = S_F;
        cnt_d   = 4'd0;
        fair_d  = 1'b1;
      end
      default: state_d = S_F;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= S_F;
      cnt_q         <= 4'd0;
      fair_q        <= 1'b0;
      addr_q        <= 16'h0000;
      wdata_q       <= 16'h0000;
      instr_q       <= NOP_INSTR;
      instr_pc_q    <= 16'h0000;
      instr_valid_q <= 1'b0;
      rdata_q       <= 16'h0000;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      fair_q        <= fair_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      rdata_q       <= rdata_d;
    end
  end

  // Load data is forwarded straight from the SRAM in the ack cycle, then held.
  assign mem_rdata_o   = (rd_last && !RST) ? ram_data_i : rdata_q;
  assign mem_ack_o     = ack && !RST;
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;
  assign instr_valid_o = instr_valid_q;

  // Strobes come from registered state only; reset kills a write pulse in the same cycle.
  assign ram_addr_o    = (state_q == S_F) ? pc_i : addr_q;
  assign ram_data_o    = wdata_q;
  assign ram_en_n_o    = 1'b0;
  assign ram_oe_n_o    = !(state_q == S_F || state_q == S_D_RD);
  assign ram_we_n_o    = (state_q != S_D_WE) || RST;
  assign ram_data_oe_o = (state_q == S_D_SETUP) || (state_q == S_D_WE) || (state_q == S_D_HOLD);

endmodule

// File: tb/tb_imem_port.sv
// Self-checking bench for imem_port: one instance with WAIT_CYCLES=1, one with WAIT_CYCLES=3,
// each on its own behavioural async SRAM.
module tb_imem_port;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: WAIT_CYCLES = 1
  logic [15:0] a_pc, a_instr, a_ipc, a_addr, a_wdata, a_rdata, a_ram_addr, a_ram_wd, a_ram_rd;
  logic        a_stall, a_valid, a_req, a_we, a_ack, a_doe, a_en_n, a_oe_n, a_we_n;
  // Instance B: WAIT_CYCLES = 3
  logic [15:0] b_pc, b_instr, b_ipc, b_addr, b_wdata, b_rdata, b_ram_addr, b_ram_wd, b_ram_rd;
  logic        b_stall, b_valid, b_req, b_we, b_ack, b_doe, b_en_n, b_oe_n, b_we_n;

  logic [15:0] mem_a [256];
  logic [15:0] mem_b [256];

  imem_port #(.WAIT_CYCLES(1), .NOP_INSTR(16'h0800)) u_w1 (
    .CLK(clk), .RST(rst), .pc_i(a_pc), .stall_pc_o(a_stall), .instr_o(a_instr),
    .instr_pc_o(a_ipc), .instr_valid_o(a_valid), .mem_req_i(a_req), .mem_we_i(a_we),
    .mem_addr_i(a_addr), .mem_wdata_i(a_wdata), .mem_rdata_o(a_rdata), .mem_ack_o(a_ack),
    .ram_addr_o(a_ram_addr), .ram_data_o(a_ram_wd), .ram_data_i(a_ram_rd),
    .ram_data_oe_o(a_doe), .ram_en_n_o(a_en_n), .ram_oe_n_o(a_oe_n), .ram_we_n_o(a_we_n)
  );

  imem_port #(.WAIT_CYCLES(3), .NOP_INSTR(16'h0800)) u_w3 (
    .CLK(clk), .RST(rst), .pc_i(b_pc), .stall_pc_o(b_stall), .instr_o(b_instr),
    .instr_pc_o(b_ipc), .instr_valid_o(b_valid), .mem_req_i(b_req), .mem_we_i(b_we),
    .mem_addr_i(b_addr), .mem_wdata_i(b_wdata), .mem_rdata_o(b_rdata), .mem_ack_o(b_ack),
    .ram_addr_o(b_ram_addr), .ram_data_o(b_ram_wd), .ram_data_i(b_ram_rd),
    .ram_data_oe_o(b_doe), .ram_en_n_o(b_en_n), .ram_oe_n_o(b_oe_n), .ram_we_n_o(b_we_n)
  );

  // Async SRAM models: combinational read, write captured at the clock edge while we_n is low.
  assign a_ram_rd = mem_a[a_ram_addr[7:0]];
  assign b_ram_rd = mem_b[b_ram_addr[7:0]];
  always @(posedge clk) begin
    if (!a_we_n && !a_en_n && a_doe) mem_a[a_ram_addr[7:0]] <= a_ram_wd;
    if (!b_we_n && !b_en_n && b_doe) mem_b[b_ram_addr[7:0]] <= b_ram_wd;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    a_req = 1'b0;
    b_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    bit          rst_before;
    bit          use_w3;
    logic [15:0] pc;
    logic        stall;
    logic        valid;
    logic [15:0] instr;
    logic [15:0] ipc;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 16'(i) ^ 16'hA500;
      mem_b[i] = 16'(i) ^ 16'hB600;
    end
    mem_a[0] = 16'h1111; mem_a[1] = 16'h2222; mem_a[2] = 16'h3333; mem_a[3] = 16'h4444;
    mem_b[5]    = 16'hABCD;
    mem_b[16]   = 16'h1234;
    mem_b[32]   = 16'h5A5A;
    mem_b[48]   = 16'h7777;
    mem_b[64]   = 16'h4040;

    vecs[0] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h1111, 16'h0000};
    vecs[1] = '{1'b0, 1'b0, 16'h0001, 1'b0, 1'b1, 16'h2222, 16'h0001};
    vecs[2] = '{1'b0, 1'b0, 16'h0002, 1'b0, 1'b1, 16'h3333, 16'h0002};
    vecs[3] = '{1'b0, 1'b0, 16'h0003, 1'b0, 1'b1, 16'h4444, 16'h0003};
    vecs[4] = '{1'b1, 1'b1, 16'h0005, 1'b1, 1'b0, 16'h0800, 16'h0000};
    vecs[5] = '{1'b0, 1'b1, 16'h0005, 1'b1, 1'b0, 16'h0800, 16'h0000};
    vecs[6] = '{1'b0, 1'b1, 16'h0005, 1'b0, 1'b1, 16'hABCD, 16'h0005};

    a_pc = 16'h0; a_req = 0; a_we = 0; a_addr = 16'h0; a_wdata = 16'h0;
    b_pc = 16'h0; b_req = 0; b_we = 0; b_addr = 16'h0; b_wdata = 16'h0;

    // Reset values
    do_reset();
    #1;
    check("rst_a_instr", a_instr, 16'h0800);
    check("rst_a_ipc", a_ipc, 16'h0000);
    check("rst_a_valid", a_valid, 0);
    check("rst_a_rdata", a_rdata, 16'h0000);
    check("rst_a_ack", a_ack, 0);
    check("rst_a_stall", a_stall, 0);
    check("rst_b_stall", b_stall, 1);
    check("rst_b_strobes", {a_en_n, a_oe_n, a_we_n, a_doe}, 16'b0010);
    check("rst_b_instr", b_instr, 16'h0800);

    // Fetch vectors
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].rst_before) do_reset();
      if (vecs[i].use_w3) b_pc = vecs[i].pc; else a_pc = vecs[i].pc;
      #1;
      check($sformatf("v%0d_stall", i), vecs[i].use_w3 ? b_stall : a_stall, vecs[i].stall);
      tick();
      check($sformatf("v%0d_valid", i), vecs[i].use_w3 ? b_valid : a_valid, vecs[i].valid);
      check($sformatf("v%0d_instr", i), vecs[i].use_w3 ? b_instr : a_instr, vecs[i].instr);
      check($sformatf("v%0d_ipc", i), vecs[i].use_w3 ? b_ipc : a_ipc, vecs[i].ipc);
    end

    // Store BEEF to 0010, then fetch 0010
    do_reset();
    b_pc = 16'h0010; b_req = 1; b_we = 1; b_addr = 16'h0010; b_wdata = 16'hBEEF;
    #1;
    check("st_acc_stall", b_stall, 1);
    check("st_acc_we_n", b_we_n, 1);
    check("st_acc_doe", b_doe, 0);
    tick();
    #1;
    check("st_setup_strb", {b_doe, b_oe_n, b_we_n, b_ack}, 16'b1110);
    check("st_setup_addr", b_ram_addr, 16'h0010);
    check("st_setup_data", b_ram_wd, 16'hBEEF);
    check("st_setup_stall", b_stall, 1);
    tick();
    #1;
    check("st_we_strb", {b_doe, b_oe_n, b_we_n, b_ack}, 16'b1100);
    check("st_we_addr", b_ram_addr, 16'h0010);
    check("st_we_data", b_ram_wd, 16'hBEEF);
    tick();
    #1;
    check("st_hold_strb", {b_doe, b_oe_n, b_we_n, b_ack}, 16'b1111);
    check("st_hold_stall", b_stall, 1);
    tick();
    b_req = 0; b_we = 0;
    #1;
    check("st_after_ack", b_ack, 0);
    found = 0;
    for (int n = 0; n < 10 && !found; n++) begin
      tick();
      if (b_valid) found = 1;
    end
    check("st_fetch_seen", 16'(found), 1);
    check("st_fetch_instr", b_instr, 16'hBEEF);
    check("st_fetch_ipc", b_ipc, 16'h0010);

    // Load 0020 held across ack: fairness lets exactly one fetch through
    do_reset();
    b_pc = 16'h0030; b_req = 1; b_we = 0; b_addr = 16'h0020;
    #1;
    check("ld_acc_stall", b_stall, 1);
    tick();
    #1;
    check("ld_rd_addr", b_ram_addr, 16'h0020);
    check("ld_rd_oe", {b_oe_n, b_doe, b_ack}, 16'b000);
    tick();
    #1;
    check("ld_rd1_ack", b_ack, 0);
    tick();
    #1;
    check("ld_rd2_ack", b_ack, 1);
    check("ld_rd2_rdata", b_rdata, 16'h5A5A);
    tick();
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("ld_fair_stall%0d", k), b_stall, (k == 2) ? 1'b0 : 1'b1);
      check($sformatf("ld_fair_ack%0d", k), b_ack, 0);
      check($sformatf("ld_fair_addr%0d", k), b_ram_addr, 16'h0030);
      tick();
    end
    check("ld_fair_valid", b_valid, 1);
    check("ld_fair_instr", b_instr, 16'h7777);
    check("ld_fair_ipc", b_ipc, 16'h0030);
    #1;
    check("ld_reacc_stall", b_stall, 1);
    tick();
    #1;
    check("ld_reacc_addr", b_ram_addr, 16'h0020);
    found = 0;
    for (int n = 0; n < 10 && !found; n++) begin
      if (b_ack) found = 1; else begin tick(); #1; end
    end
    check("ld_reacc_ack", 16'(found), 1);
    tick();
    b_req = 0;
    #1;
    check("ld_hold_rdata", b_rdata, 16'h5A5A);
    check("ld_hold_ack", b_ack, 0);

    // Request rising at cnt=1 waits for the current fetch
    do_reset();
    b_pc = 16'h0005;
    #1;
    check("mid_c0_stall", b_stall, 1);
    tick();
    b_req = 1; b_we = 0; b_addr = 16'h0020;
    #1;
    check("mid_c1_stall", b_stall, 1);
    check("mid_c1_addr", b_ram_addr, 16'h0005);
    tick();
    #1;
    check("mid_c2_stall", b_stall, 0);
    check("mid_c2_addr", b_ram_addr, 16'h0005);
    tick();
    check("mid_valid", b_valid, 1);
    check("mid_instr", b_instr, 16'hABCD);
    #1;
    check("mid_acc_stall", b_stall, 1);
    tick();
    #1;
    check("mid_rd_addr", b_ram_addr, 16'h0020);
    found = 0;
    for (int n = 0; n < 10 && !found; n++) begin
      if (b_ack) found = 1; else begin tick(); #1; end
    end
    check("mid_ack", 16'(found), 1);
    tick();
    b_req = 0;

    // Reset asserted in D_WE
    b_req = 1; b_we = 1; b_addr = 16'h0040; b_wdata = 16'hCAFE;
    found = 0;
    for (int n = 0; n < 12 && !found; n++) begin
      #1;
      if (b_doe) found = 1; else tick();
    end
    check("rwe_setup_seen", 16'(found), 1);
    tick();
    #1;
    check("rwe_we_low", b_we_n, 0);
    rst = 1;
    #1;
    check("rwe_we_forced", b_we_n, 1);
    check("rwe_no_ack", b_ack, 0);
    b_req = 0; b_we = 0;
    tick();
    #1;
    check("rwe_instr", b_instr, 16'h0800);
    check("rwe_ipc", b_ipc, 16'h0000);
    check("rwe_valid", b_valid, 0);
    check("rwe_rdata", b_rdata, 16'h0000);
    check("rwe_strobes", {b_en_n, b_oe_n, b_we_n, b_doe, b_ack}, 16'b00100);
    check("rwe_stall", b_stall, 1);
    rst = 0;
    #1;
    check("rwe_post_we_n", b_we_n, 1);
    check("rwe_mem_kept", mem_b[64], 16'h4040);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_port.md
# imem_port

Instruction-memory responder for the 16-bit pipeline; it sits at the other end of the fetch interface from the instruction-fetch stage. Each cycle it serves the fetch stage's `pc` against the external instruction SRAM, returns the instruction word, and raises `stall_pc_o` while the word is not ready. It also arbitrates one data-side port from the MEM stage, used for loads from and stores to code space, onto the same SRAM.

## Interface
- `WAIT_CYCLES`, default 1: SRAM read access length in cycles; legal range 1..15.
- `NOP_INSTR`, default 16'h0800: value of `instr_o` after reset.
- `CLK` in 1: the single clock; all state updates on its rising edge.
- `RST` in 1: reset, synchronous and active-high.
- `pc_i` in 16: fetch address from the fetch stage.
- `stall_pc_o` out 1: high means the fetch stage must hold `pc`.
- `instr_o` out 16: last captured instruction word.
- `instr_pc_o` out 16: the address `instr_o` was read from.
- `instr_valid_o` out 1: one-cycle pulse, meaning `instr_o` was updated at the preceding edge.
- `mem_req_i` in 1: data access request. The requester holds it high, with address, data and `mem_we_i` stable, until `mem_ack_o`.
- `mem_we_i` in 1: 1 = store, 0 = load.
- `mem_addr_i` in 16: data access address.
- `mem_wdata_i` in 16: store data.
- `mem_rdata_o` out 16: load result; valid in the `mem_ack_o` cycle, then held.
- `mem_ack_o` out 1: one-cycle completion pulse.
- `ram_addr_o` out 16: SRAM address.
- `ram_data_o` out 16: SRAM write data.
- `ram_data_i` in 16: SRAM read data.
- `ram_data_oe_o` out 1: drive enable for the bidirectional data pins.
- `ram_en_n_o` out 1: SRAM chip enable, active low.
- `ram_oe_n_o` out 1: SRAM output enable, active low.
- `ram_we_n_o` out 1: SRAM write enable, active low.

## Operation
- States: `F` (fetch), `D_RD`, `D_SETUP`, `D_WE`, `D_HOLD`. There is a 4-bit counter `cnt` and a `fair` flag.
- SRAM strobes (`ram_en_n_o`, `ram_oe_n_o`, `ram_we_n_o`, `ram_data_oe_o`) are decoded from registered state only. While `RST`=1, `ram_we_n_o` is forced to 1 combinationally.
- **State F:**
  - SRAM drive: `ram_addr_o`=`pc_i`, `en_n`=0, `oe_n`=0, `we_n`=1, `data_oe`=0.
  - Data acceptance: if `cnt`==0, `mem_req_i`=1 and `fair`=0, the request is accepted. Address, data and `we` are latched. The next state is `D_SETUP` if `we`=1, else `D_RD`. `stall_pc_o`=1.
  - Fetch completion: otherwise, if `cnt`==`WAIT_CYCLES`-1, `stall_pc_o`=0. At the edge: `instr_o`<=`ram_data_i`, `instr_pc_o`<=`pc_i`, `instr_valid_o`<=1, `cnt`<=0, `fair`<=0.
  - Otherwise: `stall_pc_o`=1, `cnt`++.
- **D_RD:** drives `ram_addr_o`=latched address with `oe_n`=0 for `WAIT_CYCLES` cycles. In the last cycle, `mem_rdata_o`<=`ram_data_i` and `mem_ack_o`=1. The next state is `F` with `cnt`=0 and `fair`=1.
- **Store path:**
  - `D_SETUP`: address and data driven, `data_oe`=1, `oe_n`=1, `we_n`=1.
  - `D_WE`: as `D_SETUP`, but `we_n`=0.
  - `D_HOLD`: `we_n`=1, data still driven, `mem_ack_o`=1. The next state is `F`, `cnt`=0, `fair`=1.
  - A store is always exactly 3 cycles, independent of `WAIT_CYCLES`.
- `stall_pc_o`=1 in every D state.
- **Fairness:** `fair`=1 blocks data acceptance until one fetch completes. Consequences:
  - A fetch is never starved.
  - A data request waits at most one fetch (`WAIT_CYCLES` cycles) before being accepted.
- **Mid-fetch arrivals:** a `mem_req_i` that rises while `cnt`>0 waits until the current fetch completes. That fetch is never aborted.
- **Store to the word being fetched next:** the following fetch reads the new value, because the store finishes before that fetch starts.

## Timing
- **Reset values (the edge with `RST`=1):**
  - State and counters: state=`F`, `cnt`=0, `fair`=0.
  - Instruction outputs: `instr_o`=`NOP_INSTR`, `instr_pc_o`=0, `instr_valid_o`=0.
  - Data outputs: `mem_rdata_o`=0, `mem_ack_o`=0.
  - Strobes: `en_n`=0, `oe_n`=0, `we_n`=1, `data_oe`=0 (the `F` decode).
  - `stall_pc_o`=1 if `WAIT_CYCLES`>1, else 0.
- **Reset during a D state:** the access is abandoned with no ack, and `we_n` goes high in the same cycle.
- **Fetch throughput:** with `WAIT_CYCLES`=1 and no data traffic, `stall_pc_o`=0 every cycle and one instruction is delivered per cycle. In general, one instruction every `WAIT_CYCLES` cycles.
- **Latency:** `instr_o`/`instr_valid_o` appear one edge after the completing cycle. That is the same edge at which the fetch stage advances `pc`, so `instr_pc_o` equals the fetch stage's previous `pc`.
- **Data latency** from acceptance to `mem_ack_o`: a load takes `WAIT_CYCLES` cycles (ack in its last cycle); a store takes 3 cycles (ack in `D_HOLD`).
- **Requester rule:** the requester drops `mem_req_i` the cycle after `mem_ack_o`. If it is still high it counts as a new request, which `fair` delays by one fetch.
- `pc_i` must be stable while `stall_pc_o`=1. A change during that time is undefined.

## Test plan
- Reset, `WAIT_CYCLES`=1, SRAM preloaded with mem[0..3]=16'h1111,2222,3333,4444 and `pc` incrementing from 0 → `stall_pc_o` never high; `instr_o` takes 1111..4444 on consecutive cycles; `instr_pc_o`=0..3.
- `WAIT_CYCLES`=3, `pc`=5, mem[5]=16'hABCD → `stall_pc_o` high 2 cycles then low 1; `instr_o`=ABCD with `instr_valid_o` pulse one cycle later.
- Store `mem_addr_i`=16'h0010, `wdata`=16'hBEEF while `cnt`==0 → `D_SETUP`/`D_WE`/`D_HOLD`; `we_n` low exactly 1 cycle with address 0010 and data BEEF; `mem_ack_o` in cycle 3; a subsequent fetch of `pc`=0010 returns BEEF.
- Load at 16'h0020 (mem=16'h5A5A) held high across ack → `mem_rdata_o`=5A5A; then exactly one fetch completes before the repeated request is accepted (fairness).
- `mem_req_i` rising at `cnt`=1 with `WAIT_CYCLES`=3 → the fetch completes undisturbed; the data access starts on the next cycle.
- `RST` asserted in `D_WE` → `we_n` high in that cycle, no `mem_ack_o`, and the outputs match the reset values.
